// File: rtl/led_ws2812_tx.sv
// Purpose: WS2812 single-wire transmitter; sends NUM_LEDS GRB-ordered colours, then a latch low period.
// Latency: data_out/busy rise one cycle after enviar is sampled in IDLE; all outputs registered.
// Backpressure: none; enviar is ignored while busy, cor_led must be valid whenever a sample can occur.
//
// Ports:
//   clock, reset_n   : rising-edge clock, synchronous active-low reset
//   enviar           : frame start request, level-sampled in IDLE only
//   cor_led[23:0]    : RGB colour (R[23:16] G[15:8] B[7:0]) for LED led_idx
//   led_idx          : index of the LED whose colour is sampled next
//   data_out         : registered LED data line
//   busy             : high for the whole frame (bits + latch)
//   done             : one-cycle pulse in the first IDLE cycle after the latch
module led_ws2812_tx #(
    parameter int NUM_LEDS  = 8,
    parameter int IDX_W     = 8,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int RESET_CYC = 15000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enviar,
    input  logic [23:0]      cor_led,
    output logic [IDX_W-1:0] led_idx,
    output logic             data_out,
    output logic             busy,
    output logic             done
);

    localparam int T_W = $clog2(BIT_CYC);
    localparam int L_W = $clog2(RESET_CYC + 1);

    localparam logic [T_W-1:0]   BIT_LAST = T_W'(BIT_CYC - 1);
    localparam logic [T_W-1:0]   T0H_T    = T_W'(T0H_CYC);
    localparam logic [T_W-1:0]   T1H_T    = T_W'(T1H_CYC);
    localparam logic [L_W-1:0]   LAT_LAST = L_W'(RESET_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;          // cycle within the current bit
    logic [4:0]       bit_q, bit_d;      // bits already finished in the current LED
    logic [IDX_W-1:0] led_q, led_d;      // LED currently being sent
    logic [IDX_W-1:0] idx_q, idx_d;      // next LED to sample (wraps after last)
    logic [23:0]      sr_q, sr_d;        // GRB shift register, MSB on the wire
    logic [L_W-1:0]   lat_q, lat_d;      // latch period counter
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [T_W-1:0]   thr_d;

    // WS2812 expects green first, then red, then blue.
    function automatic logic [23:0] to_grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
        return (i == LAST_LED) ? '0 : i + IDX_W'(1);
    endfunction

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            bit_q   <= '0;
            led_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            lat_q   <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            bit_q   <= bit_d;
            led_q   <= led_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        bit_d   = bit_q;
        led_d   = led_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        lat_d   = lat_q;
        unique case (state_q)
            S_IDLE: begin
                if (enviar) begin
                    state_d = S_SEND;
                    sr_d    = to_grb(cor_led);
                    idx_d   = idx_next('0);
                    t_d     = '0;
                    bit_d   = '0;
                    led_d   = '0;
                    lat_d   = '0;
                end
            end
            S_SEND: begin
                if (t_q == BIT_LAST) begin
                    t_d = '0;
                    if (bit_q != 5'd23) begin
                        sr_d  = {sr_q[22:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                    end else if (led_q != LAST_LED) begin
                        // Back-to-back reload: next LED's first bit starts on the following cycle.
                        sr_d  = to_grb(cor_led);
                        bit_d = '0;
                        led_d = led_q + IDX_W'(1);
                        idx_d = idx_next(idx_q);
                    end else begin
                        state_d = S_LATCH;
                        lat_d   = '0;
                    end
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_LATCH: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + L_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registered line
    // lines up exactly with the bit timer.
    always_comb begin
        thr_d  = sr_d[23] ? T1H_T : T0H_T;
        data_d = (state_d == S_SEND) && (t_d < thr_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_LATCH) && (state_d == S_IDLE);
    end

    assign led_idx  = idx_q;
    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
